operand_fetch: RTL and testbench

Operand-fetch and writeback arbiter that sits in front of the 32×16-bit register file. It owns both register-file read ports and the single write port. It accepts decoded instructions and stalls them on register hazards using a per-register busy scoreboard. It forwards same-cycle writeback data and hands registered operands to the execute stage over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/operand_fetch_if.sv | 42 ++++
 rtl/operand_fetch_scoreboard.sv | 44 ++++
 rtl/operand_fetch.sv | 90 +++++++++
 tb/tb_operand_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: register/data widths, fetch bundle handed to execute,
// output-stage state encoding and a popcount helper for the scoreboard.
package cpu_pkg;
   localparam int DATA_W = 16;
   localparam int AREG_W = 5;
   localparam int NREGS  = 1 << AREG_W;

   typedef logic [AREG_W-1:0] regaddr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      data_t    a;
      data_t    b;
      regaddr_t rd;
      logic     writes_rd;
   } fetch_bundle_t;

   typedef enum logic {OS_EMPTY, OS_FULL} ostate_t;

   function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < NREGS; i++) c = c + 6'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Decode-in, execute-out, writeback and register-file port bundle of operand_fetch.
interface operand_fetch_if;
   import cpu_pkg::*;

   logic     in_valid, in_ready;
   regaddr_t in_rs1, in_rs2, in_rd;
   logic     in_use_rs1, in_use_rs2, in_writes_rd;

   logic     out_valid, out_ready;
   data_t    out_a, out_b;
   regaddr_t out_rd;
   logic     out_writes_rd;

   logic     wb_valid;
   regaddr_t wb_addr;
   data_t    wb_data;

   logic     rf_read_a, rf_read_b;
   regaddr_t rf_a_addr, rf_b_addr;
   data_t    rf_a_data, rf_b_data;
   logic     rf_write;
   regaddr_t rf_w_addr;
   data_t    rf_d_in;

   logic [5:0] busy_cnt;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_writes_rd,
      input  out_ready, wb_valid, wb_addr, wb_data, rf_a_data, rf_b_data,
      output in_ready, out_valid, out_a, out_b, out_rd, out_writes_rd,
      output rf_read_a, rf_read_b, rf_a_addr, rf_b_addr, rf_write, rf_w_addr, rf_d_in,
      output busy_cnt
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_writes_rd,
      output out_ready, wb_valid, wb_addr, wb_data, rf_a_data, rf_b_data,
      input  in_ready, out_valid, out_a, out_b, out_rd, out_writes_rd,
      input  rf_read_a, rf_read_b, rf_a_addr, rf_b_addr, rf_write, rf_w_addr, rf_d_in,
      input  busy_cnt
   );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits with set/clear, three lookups and a registered popcount.
// Set beats clear when both target the same register; r0 never goes busy.
module scoreboard
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       set_en,
   input  regaddr_t   set_addr,
   input  logic       clr_en,
   input  regaddr_t   clr_addr,
   input  regaddr_t   src_a,
   input  regaddr_t   src_b,
   input  regaddr_t   dst,
   output logic       busy_a,
   output logic       busy_b,
   output logic       busy_d,
   output logic [5:0] busy_cnt
);
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:0] busy, busy_nxt;

   assign busy   = {busy_q, 1'b0};
   assign busy_a = busy[src_a];
   assign busy_b = busy[src_b];
   assign busy_d = busy[dst];

   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[clr_addr] = 1'b0;
      if (set_en) busy_nxt[set_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         busy_q   <= busy_nxt[NREGS-1:1];
         busy_cnt <= popcount(busy_nxt);
      end
   end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: hazard stall via scoreboard, writeback bypass, one-entry output
// stage toward execute, and ownership of the register-file read/write ports.
module operand_fetch
   import cpu_pkg::*;
(
   input logic             clk,
   input logic             reset,
   operand_fetch_if.slave  bus
);
   ostate_t       state, state_nxt;
   fetch_bundle_t ob, ob_nxt;
   logic          busy_a, busy_b, busy_d;
   logic          hit_a, hit_b, hit_d, hazard, accept, wb_ok;

   function automatic data_t pick(input logic en, input regaddr_t rs, input logic hit,
                                  input data_t wbd, input data_t rfd);
      if (!en || rs == '0) return '0;
      if (hit)             return wbd;
      return rfd;
   endfunction

   assign wb_ok = bus.wb_valid && bus.wb_addr != '0 && !reset;
   assign hit_a = bus.wb_valid && bus.wb_addr == bus.in_rs1;
   assign hit_b = bus.wb_valid && bus.wb_addr == bus.in_rs2;
   assign hit_d = bus.wb_valid && bus.wb_addr == bus.in_rd;

   // A writeback landing this cycle releases its register, so hazards see through it.
   assign hazard = (bus.in_use_rs1 && busy_a && !hit_a) ||
                   (bus.in_use_rs2 && busy_b && !hit_b) ||
                   (ob_nxt.writes_rd && busy_d && !hit_d);

   assign bus.in_ready = !reset && !hazard && (state == OS_EMPTY || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      ob_nxt.a         = pick(bus.in_use_rs1, bus.in_rs1, hit_a, bus.wb_data, bus.rf_a_data);
      ob_nxt.b         = pick(bus.in_use_rs2, bus.in_rs2, hit_b, bus.wb_data, bus.rf_b_data);
      ob_nxt.rd        = bus.in_rd;
      ob_nxt.writes_rd = bus.in_writes_rd && bus.in_rd != '0;
   end

   scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (accept && ob_nxt.writes_rd),
      .set_addr (bus.in_rd),
      .clr_en   (wb_ok),
      .clr_addr (bus.wb_addr),
      .src_a    (bus.in_rs1),
      .src_b    (bus.in_rs2),
      .dst      (bus.in_rd),
      .busy_a   (busy_a),
      .busy_b   (busy_b),
      .busy_d   (busy_d),
      .busy_cnt (bus.busy_cnt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         OS_EMPTY: if (accept) state_nxt = OS_FULL;
         OS_FULL:  if (bus.out_ready && !accept) state_nxt = OS_EMPTY;
         default:  state_nxt = OS_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= OS_EMPTY;
         ob    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) ob <= ob_nxt;
      end
   end

   assign bus.out_valid     = (state == OS_FULL);
   assign bus.out_a         = ob.a;
   assign bus.out_b         = ob.b;
   assign bus.out_rd        = ob.rd;
   assign bus.out_writes_rd = ob.writes_rd;

   assign bus.rf_read_a = bus.in_use_rs1 && bus.in_valid;
   assign bus.rf_read_b = bus.in_use_rs2 && bus.in_valid;
   assign bus.rf_a_addr = bus.in_rs1;
   assign bus.rf_b_addr = bus.in_rs2;
   assign bus.rf_write  = wb_ok;
   assign bus.rf_w_addr = bus.wb_addr;
   assign bus.rf_d_in   = bus.wb_data;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, all compared
// against a set/array reference model of scoreboard, output slot and register file.
module tb_operand_fetch;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   operand_fetch_if bif();
   operand_fetch dut (.clk(clk), .reset(reset), .bus(bif.slave));

   always #5 clk = ~clk;

   // Reference state
   data_t    rf_mem [NREGS];
   bit       m_busy [NREGS];
   bit       m_full;
   data_t    m_a, m_b;
   regaddr_t m_rd;
   bit       m_wr;
   logic     last_rdy;

   // RF model commits after the rising edge, so a missing bypass shows up.
   always_comb begin
      bif.rf_a_data = rf_mem[bif.rf_a_addr];
      bif.rf_b_data = rf_mem[bif.rf_b_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic data_t src_val(input bit en, input regaddr_t rs);
      if (!en || rs == 0) return 0;
      if (bif.wb_valid && bif.wb_addr == rs) return bif.wb_data;
      return rf_mem[rs];
   endfunction

   function automatic int busy_total();
      int c = 0;
      foreach (m_busy[i]) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic set_in(input bit v, input int r1, input int r2, input int rd,
                         input bit u1, input bit u2, input bit wr, input bit ordy);
      bif.in_valid = v;  bif.in_rs1 = regaddr_t'(r1); bif.in_rs2 = regaddr_t'(r2);
      bif.in_rd = regaddr_t'(rd); bif.in_use_rs1 = u1; bif.in_use_rs2 = u2;
      bif.in_writes_rd = wr; bif.out_ready = ordy;
   endtask

   task automatic set_wb(input bit v, input int a, input data_t d);
      bif.wb_valid = v; bif.wb_addr = regaddr_t'(a); bif.wb_data = d;
   endtask

   // One clock: check everything against the model before the edge, then advance it.
   task automatic tick();
      bit h, rdy, acc, wbw;
      data_t na, nb;
      @(negedge clk);
      h = (bif.in_use_rs1 && m_busy[bif.in_rs1] && !(bif.wb_valid && bif.wb_addr == bif.in_rs1)) ||
          (bif.in_use_rs2 && m_busy[bif.in_rs2] && !(bif.wb_valid && bif.wb_addr == bif.in_rs2)) ||
          (bif.in_writes_rd && bif.in_rd != 0 && m_busy[bif.in_rd] &&
           !(bif.wb_valid && bif.wb_addr == bif.in_rd));
      rdy = !reset && !h && (!m_full || bif.out_ready);
      wbw = bif.wb_valid && bif.wb_addr != 0 && !reset;
      chk("in_ready",  bif.in_ready, rdy);
      chk("rf_write",  bif.rf_write, wbw);
      chk("rf_read_a", bif.rf_read_a, bif.in_valid && bif.in_use_rs1);
      chk("rf_read_b", bif.rf_read_b, bif.in_valid && bif.in_use_rs2);
      chk("rf_a_addr", bif.rf_a_addr, bif.in_rs1);
      chk("rf_w_addr", bif.rf_w_addr, bif.wb_addr);
      chk("rf_d_in",   bif.rf_d_in, bif.wb_data);
      chk("out_valid", bif.out_valid, m_full);
      chk("out_a",     bif.out_a, m_a);
      chk("out_b",     bif.out_b, m_b);
      chk("out_rd",    bif.out_rd, m_rd);
      chk("out_wr",    bif.out_writes_rd, m_wr);
      chk("busy_cnt",  bif.busy_cnt, busy_total());
      last_rdy = bif.in_ready;
      acc = bif.in_valid && rdy;
      na = src_val(bif.in_use_rs1, bif.in_rs1);
      nb = src_val(bif.in_use_rs2, bif.in_rs2);
      @(posedge clk);
      if (reset) begin
         m_full = 0; m_a = 0; m_b = 0; m_rd = 0; m_wr = 0;
         foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
         if (wbw) begin
            m_busy[bif.wb_addr] = 0;
            rf_mem[bif.wb_addr] = bif.wb_data;
         end
         if (acc) begin
            m_full = 1; m_a = na; m_b = nb; m_rd = bif.in_rd;
            m_wr = bif.in_writes_rd && bif.in_rd != 0;
            if (m_wr) m_busy[bif.in_rd] = 1;
         end else if (bif.out_ready) m_full = 0;
      end
      #1;
   endtask

   initial begin
      data_t hold_a;
      foreach (rf_mem[i]) rf_mem[i] = (i == 0) ? 16'h0 : data_t'($urandom);
      foreach (m_busy[i]) m_busy[i] = 0;
      m_full = 0; m_a = 0; m_b = 0; m_rd = 0; m_wr = 0;
      reset = 1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 4, 16'h5555);
      tick(); tick();
      reset = 0;
      set_wb(0, 0, 0);

      // Basic accept with register-file operands
      rf_mem[3] = 16'h1111; rf_mem[4] = 16'h2222;
      set_in(1, 3, 4, 5, 1, 1, 1, 0);
      tick();
      chk("t1_ready", last_rdy, 1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("t1_a", bif.out_a, 16'h1111);
      chk("t1_b", bif.out_b, 16'h2222);
      chk("t1_cnt", bif.busy_cnt, 1);

      // RAW stall on r5, released by same-cycle writeback with bypass
      set_in(1, 5, 0, 6, 1, 0, 0, 1);
      tick(); tick();
      chk("raw_stall", last_rdy, 0);
      set_wb(1, 5, 16'hBEEF);
      tick();
      chk("raw_release", last_rdy, 1);
      set_wb(0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("raw_bypass", bif.out_a, 16'hBEEF);
      chk("raw_cnt", bif.busy_cnt, 0);

      // r0 everywhere, plus writeback to r0
      set_in(1, 0, 0, 0, 1, 1, 1, 1);
      set_wb(1, 0, 16'h7777);
      tick();
      chk("r0_nowrite", bif.rf_write, 0);
      set_wb(0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("r0_a", bif.out_a, 0);
      chk("r0_wr", bif.out_writes_rd, 0);
      chk("r0_cnt", bif.busy_cnt, 0);

      // Backpressure: bundle held stable, then back-to-back replacement
      rf_mem[8] = 16'h0808;
      set_in(1, 8, 0, 0, 1, 0, 0, 0);
      hold_a = bif.out_a;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stall", last_rdy, 0);
         chk("bp_stable", bif.out_a, hold_a);
      end
      bif.out_ready = 1;
      tick();
      chk("bp_b2b", last_rdy, 1);
      chk("bp_new", bif.out_a, 16'h0808);

      // WAW on r7 cleared by same-cycle writeback: set wins
      set_in(1, 0, 0, 7, 0, 0, 1, 1);
      tick();
      set_wb(1, 7, 16'h0707);
      tick();
      chk("waw_accept", last_rdy, 1);
      set_wb(0, 0, 0);
      set_in(1, 7, 0, 0, 1, 0, 0, 1);
      tick();
      chk("waw_busy", last_rdy, 0);

      // Reset mid-flight with busy r9 and a pending writeback
      set_in(1, 0, 0, 9, 0, 0, 1, 0);
      tick();
      reset = 1;
      set_wb(1, 9, 16'h9999);
      tick();
      chk("rst_wb", last_rdy, 0);
      chk("rst_valid", bif.out_valid, 0);
      chk("rst_cnt", bif.busy_cnt, 0);
      reset = 0;
      set_wb(0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("rst_rf", rf_mem[9] == 16'h9999, 0);

      // Random traffic over a small register window to provoke hazards
      for (int c = 0; c < 1500; c++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         set_wb($urandom_range(0, 9) < 4, $urandom_range(0, 7), data_t'($urandom));
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
